cla_error_monitor: RTL and testbench
====================================

// Module: cla_error_monitor
// PURPOSE
//  Downstream consumer of the 16-bit CLA adder under evaluation. Each sample it takes
//  the operands the adder was driven with (op_a, op_b, cin) and the adder's result
//  (approx_sum). It computes the exact reference sum internally and accumulates error
//  statistics over a run of num_samples samples: error count, maximum error distance
//  and summed error distance. The results are used for approximate-adder quality
//  scoring, replacing per-sample dumps to file with on-chip metrics.
// PARAMETERS
//  W      16  operand width; the sum is W+1 bits wide
//  CNT_W  32  width of the sample and error counters and of num_samples
//  ACC_W  48  width of the summed-error-distance accumulator
// PORTS
//  clk          in   1        single clock, rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  start        in   1        1-cycle pulse; begins a new run and clears the statistics
//  num_samples  in   CNT_W    samples per run; sampled only when start=1
//  in_valid     in   1        operand/result sample is valid
//  in_ready     out  1        block accepts a sample; a sample is taken when in_valid & in_ready
//  op_a         in   W        adder operand A
//  op_b         in   W        adder operand B
//  cin          in   1        adder carry-in
//  approx_sum   in   W+1      adder result under test
//  busy         out  1        high in RUN and DRAIN
//  done         out  1        high in DONE; held until the next start or a reset
//  sample_cnt   out  CNT_W    number of samples accumulated so far
//  err_cnt      out  CNT_W    number of samples with approx_sum != exact sum
//  max_ed       out  W+1      maximum |exact - approx_sum| seen in the run
//  sum_ed       out  ACC_W    sum of |exact - approx_sum|; saturates at all ones
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - All outputs, counters and pipeline valid bits are 0; state goes to IDLE.
//   - Reset applies in any state, including mid-RUN or mid-DRAIN.
//  FSM states: IDLE, RUN, DRAIN, DONE. All outputs are registered or decoded from state
//  only (Moore); in_ready = (state==RUN).
//   - start=1 in any state: clear all statistics and both pipeline valid bits.
//     Next state is RUN, or DONE if num_samples==0. start has priority over all
//     other events in the same cycle.
//   - RUN -> DRAIN: on the edge that accepts sample number num_samples.
//   - DRAIN -> DONE: on the edge after the last accumulator update, i.e. when both
//     pipeline valid bits are 0.
//   - IDLE and DONE: in_valid is ignored and no sample is counted.
//  Pipeline: 3 stages for a sample accepted at edge k.
//   - Edge k: S1 registers exact = op_a + op_b + cin (W+1 bits, no overflow) and
//     approx_sum.
//   - Edge k+1: S2 registers ed = |exact - approx_sum|, an unsigned W+1-bit magnitude.
//   - Edge k+2: update the statistics.
//       sample_cnt += 1
//       err_cnt    += (ed != 0)
//       max_ed      = max(max_ed, ed)
//       sum_ed      = sat(sum_ed + ed)
//   - Back-to-back samples are accepted at full rate (one per cycle).
//   - For the last sample, done rises at edge k+3.
//  Counters never wrap: sample_cnt is at most num_samples, and sum_ed saturates.
// TESTING
//  T1 Reset: apply rst_n=0 mid-RUN.
//     -> All outputs are 0 and in_ready=0 immediately.
//     -> After release, the block stays IDLE.
//  T2 Exact adder: num_samples=4 with approx_sum equal to the exact sum.
//     -> sample_cnt=4, err_cnt=0, max_ed=0, sum_ed=0.
//     -> done rises 3 cycles after the 4th accept.
//  T3 Error case: num_samples=2 with these samples:
//       (A) a=FFFF, b=0001, cin=0, approx=00000 -> ed=0x10000
//       (B) a=000A, b=0005, cin=1, approx=00014 -> ed=4
//     -> err_cnt=2, max_ed=0x10000, sum_ed=65540.
//  T4 Empty run: num_samples=0.
//     -> done=1 on the next cycle; all counters are 0; in_ready never rises.
//  T5 Gaps and extra input: num_samples=3 with in_valid toggling 1,0,1,0,1, then held
//     high in DONE.
//     -> sample_cnt=3; extra valids are not counted.
//  T6 Restart: pulse start mid-RUN after 2 accepts, with num_samples=1.
//     -> Statistics clear; in-flight samples are discarded.
//     -> Final sample_cnt=1.

Source files
------------

// File: rtl/cla_error_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : cla_error_monitor_if
// Purpose  : Sample bus between a CLA adder harness and the error monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface cla_error_monitor_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic [W:0]   approx_sum;

  modport master (
    output in_valid, op_a, op_b, cin, approx_sum,
    input  in_ready
  );

  modport slave (
    input  in_valid, op_a, op_b, cin, approx_sum,
    output in_ready
  );
endinterface
`default_nettype wire

// File: rtl/cla_error_monitor.sv
`default_nettype none
// ============================================================================
// Module   : cla_error_monitor
// Purpose  : Compares an approximate adder result with the exact sum and
//            accumulates error count, max and summed error distance per run.
// Revision : 1.0 - initial release
// ============================================================================
module cla_error_monitor #(
  parameter int W     = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             start,
  input  wire logic [CNT_W-1:0] num_samples,
  cla_error_monitor_if.slave    s,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      sample_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [W:0]            max_ed,
  output logic [ACC_W-1:0]      sum_ed
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_acc_cnt;
  logic             r_s1_vld;
  logic [W:0]       r_s1_exact;
  logic [W:0]       r_s1_approx;
  logic             r_s2_vld;
  logic [W:0]       r_s2_ed;

  logic             w_accept;
  logic [CNT_W-1:0] w_acc_next;
  logic [W:0]       w_exact;
  logic [W:0]       w_ed;
  logic [ACC_W:0]   w_sum_ext;

  assign s.in_ready = (r_state == ST_RUN);
  assign busy       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done       = (r_state == ST_DONE);

  assign w_accept   = s.in_valid && (r_state == ST_RUN);
  assign w_acc_next = r_acc_cnt + CNT_W'(1);
  assign w_exact    = (W+1)'(s.op_a) + (W+1)'(s.op_b) + (W+1)'(s.cin);
  assign w_ed       = (r_s1_exact >= r_s1_approx) ? (r_s1_exact - r_s1_approx)
                                                  : (r_s1_approx - r_s1_exact);
  // One extra bit catches the carry out so the accumulator can saturate.
  assign w_sum_ext  = {1'b0, sum_ed} + (ACC_W+1)'(r_s2_ed);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_num       <= '0;
      r_acc_cnt   <= '0;
      r_s1_vld    <= 1'b0;
      r_s1_exact  <= '0;
      r_s1_approx <= '0;
      r_s2_vld    <= 1'b0;
      r_s2_ed     <= '0;
      sample_cnt  <= '0;
      err_cnt     <= '0;
      max_ed      <= '0;
      sum_ed      <= '0;
    end else if (start) begin
      // Restart discards anything still in the pipeline.
      r_state    <= (num_samples == '0) ? ST_DONE : ST_RUN;
      r_num      <= num_samples;
      r_acc_cnt  <= '0;
      r_s1_vld   <= 1'b0;
      r_s2_vld   <= 1'b0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      max_ed     <= '0;
      sum_ed     <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_exact  <= w_exact;
        r_s1_approx <= s.approx_sum;
      end

      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_ed <= w_ed;
      end

      if (r_s2_vld) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
        err_cnt    <= err_cnt + CNT_W'(r_s2_ed != '0);
        if (r_s2_ed > max_ed) begin
          max_ed <= r_s2_ed;
        end
        sum_ed <= w_sum_ext[ACC_W] ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
      end

      case (r_state)
        ST_RUN: begin
          if (w_accept) begin
            r_acc_cnt <= w_acc_next;
            if (w_acc_next == r_num) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!r_s1_vld && !r_s2_vld) begin
            r_state <= ST_DONE;
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cla_error_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_error_monitor
// Purpose  : Directed self-checking bench for cla_error_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_error_monitor;

  localparam int c_w     = 16;
  localparam int c_cnt_w = 32;
  // Narrow accumulator so saturation is reachable with a few samples.
  localparam int c_acc_w = 17;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [c_cnt_w-1:0] num_samples = '0;
  logic               busy, done;
  logic [c_cnt_w-1:0] sample_cnt, err_cnt;
  logic [c_w:0]       max_ed;
  logic [c_acc_w-1:0] sum_ed;

  int total = 0;
  int bad   = 0;

  cla_error_monitor_if #(.W(c_w)) bus ();

  cla_error_monitor #(
    .W(c_w), .CNT_W(c_cnt_w), .ACC_W(c_acc_w)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .s(bus.slave), .busy(busy), .done(done), .sample_cnt(sample_cnt),
    .err_cnt(err_cnt), .max_ed(max_ed), .sum_ed(sum_ed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [c_cnt_w-1:0] n);
    start = 1'b1;
    num_samples = n;
    tick();
    start = 1'b0;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic [16:0] approx);
    bus.op_a = a;
    bus.op_b = b;
    bus.cin = c;
    bus.approx_sum = approx;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic [16:0] approx);
    drive(a, b, c, approx);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (done) ok = 1'b1;
      else tick();
    end
    if (done) ok = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    total++; if ({busy, done, bus.in_ready} !== 3'b000 || sample_cnt !== 0 || sum_ed !== 0) begin
      bad++; $display("FAIL reset_initial: busy/done/rdy=%b cnt=%0d sum=%0d want 000/0/0",
                      {busy, done, bus.in_ready}, sample_cnt, sum_ed);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    do_start(4);
    send(16'h0001, 16'h0001, 1'b0, 17'h00009);
    send(16'h0002, 16'h0002, 1'b0, 17'h00000);
    tick(); tick();
    total++; if (sample_cnt !== 2) begin
      bad++; $display("FAIL reset_prefill: sample_cnt=%0d want 2", sample_cnt);
    end
    #3 rst_n = 1'b0;
    #1;
    total++; if ({busy, done, bus.in_ready} !== 3'b000 || sample_cnt !== 0 || err_cnt !== 0 ||
                 max_ed !== 0 || sum_ed !== 0) begin
      bad++; $display("FAIL reset_midrun: flags=%b cnt=%0d err=%0d max=%0d sum=%0d want all 0",
                      {busy, done, bus.in_ready}, sample_cnt, err_cnt, max_ed, sum_ed);
    end
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    total++; if ({busy, done, bus.in_ready} !== 3'b000 || sample_cnt !== 0) begin
      bad++; $display("FAIL reset_idle: flags=%b cnt=%0d want 000/0",
                      {busy, done, bus.in_ready}, sample_cnt);
    end
  endtask

  task automatic test_exact();
    do_start(4);
    total++; if (bus.in_ready !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL exact_run: in_ready=%b busy=%b want 1/1", bus.in_ready, busy);
    end
    send(16'h1234, 16'h4321, 1'b0, 17'h05555);
    send(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
    send(16'h8000, 16'h8000, 1'b0, 17'h10000);
    send(16'h0000, 16'h0000, 1'b1, 17'h00001);
    tick(); tick();
    total++; if (done !== 1'b0) begin
      bad++; $display("FAIL exact_done_early: done=%b want 0 at k+2", done);
    end
    tick();
    total++; if (done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL exact_done_k3: done=%b busy=%b want 1/0", done, busy);
    end
    total++; if (sample_cnt !== 4 || err_cnt !== 0 || max_ed !== 0 || sum_ed !== 0) begin
      bad++; $display("FAIL exact_stats: cnt=%0d err=%0d max=%0d sum=%0d want 4/0/0/0",
                      sample_cnt, err_cnt, max_ed, sum_ed);
    end
  endtask

  task automatic test_error();
    bit ok;
    do_start(2);
    send(16'hFFFF, 16'h0001, 1'b0, 17'h00000);
    send(16'h000A, 16'h0005, 1'b1, 17'h00014);
    wait_done(20, ok);
    total++; if (!ok) begin
      bad++; $display("FAIL error_timeout: done=%b want 1", done);
    end
    total++; if (sample_cnt !== 2 || err_cnt !== 2 || max_ed !== 17'h10000 || sum_ed !== 65540) begin
      bad++; $display("FAIL error_stats: cnt=%0d err=%0d max=%h sum=%0d want 2/2/10000/65540",
                      sample_cnt, err_cnt, max_ed, sum_ed);
    end
  endtask

  task automatic test_empty();
    bit rdy_seen;
    rdy_seen = 1'b0;
    do_start(0);
    total++; if (done !== 1'b1 || sample_cnt !== 0 || err_cnt !== 0 || max_ed !== 0 || sum_ed !== 0) begin
      bad++; $display("FAIL empty_done: done=%b cnt=%0d err=%0d max=%0d sum=%0d want 1/0/0/0/0",
                      done, sample_cnt, err_cnt, max_ed, sum_ed);
    end
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    total++; if (rdy_seen !== 1'b0 || sample_cnt !== 0) begin
      bad++; $display("FAIL empty_ready: ready_seen=%b cnt=%0d want 0/0", rdy_seen, sample_cnt);
    end
  endtask

  task automatic test_gaps();
    bit ok;
    do_start(3);
    drive(16'h0100, 16'h0020, 1'b1, 17'h00121);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      tick();
    end
    bus.in_valid = 1'b1;
    wait_done(20, ok);
    total++; if (!ok) begin
      bad++; $display("FAIL gaps_timeout: done=%b want 1", done);
    end
    tick(); tick(); tick();
    total++; if (sample_cnt !== 3 || err_cnt !== 0 || bus.in_ready !== 1'b0 || done !== 1'b1) begin
      bad++; $display("FAIL gaps_stats: cnt=%0d err=%0d rdy=%b done=%b want 3/0/0/1",
                      sample_cnt, err_cnt, bus.in_ready, done);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_restart();
    bit ok;
    do_start(5);
    send(16'h0001, 16'h0001, 1'b0, 17'h00009);
    send(16'h0001, 16'h0001, 1'b0, 17'h00009);
    // Valid stays high through the start cycle: start must win over the accept.
    drive(16'h0002, 16'h0003, 1'b0, 17'h00002);
    bus.in_valid = 1'b1;
    do_start(1);
    total++; if (sample_cnt !== 0 || sum_ed !== 0 || busy !== 1'b1) begin
      bad++; $display("FAIL restart_clear: cnt=%0d sum=%0d busy=%b want 0/0/1", sample_cnt, sum_ed, busy);
    end
    tick();
    bus.in_valid = 1'b0;
    wait_done(20, ok);
    total++; if (!ok) begin
      bad++; $display("FAIL restart_timeout: done=%b want 1", done);
    end
    total++; if (sample_cnt !== 1 || err_cnt !== 1 || max_ed !== 3 || sum_ed !== 3) begin
      bad++; $display("FAIL restart_stats: cnt=%0d err=%0d max=%0d sum=%0d want 1/1/3/3",
                      sample_cnt, err_cnt, max_ed, sum_ed);
    end
  endtask

  task automatic test_saturate();
    bit ok;
    do_start(3);
    send(16'hFFFF, 16'h0001, 1'b0, 17'h00000);
    send(16'hFFFF, 16'h0001, 1'b0, 17'h00000);
    send(16'hFFFF, 16'h0001, 1'b0, 17'h00000);
    wait_done(20, ok);
    total++; if (!ok) begin
      bad++; $display("FAIL sat_timeout: done=%b want 1", done);
    end
    total++; if (sample_cnt !== 3 || err_cnt !== 3 || max_ed !== 17'h10000 || sum_ed !== 17'h1FFFF) begin
      bad++; $display("FAIL sat_stats: cnt=%0d err=%0d max=%h sum=%h want 3/3/10000/1ffff",
                      sample_cnt, err_cnt, max_ed, sum_ed);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    drive(16'h0, 16'h0, 1'b0, 17'h0);
    test_reset();
    test_exact();
    test_error();
    test_empty();
    test_gaps();
    test_restart();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
